// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and elaboration helpers for the cpu run monitor.
package cpu_run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    localparam int DRAIN_CNT_W = 8;

    // Legal parameter space: the counter must hold MAX_CYCLES+DRAIN_CYCLES without wrapping.
    function automatic bit params_ok(input int cyc_w, input int max_cycles,
                                     input int drain_cycles, input int num_watch);
        longint lim;
        lim = longint'(1) << cyc_w;
        return (max_cycles >= 1) && (longint'(max_cycles) < lim) &&
               (drain_cycles >= 0) && (drain_cycles <= 255) &&
               (longint'(max_cycles) + longint'(drain_cycles) < lim) &&
               (num_watch >= 1) && (num_watch <= 16);
    endfunction

endpackage

// File: rtl/cpu_run_monitor.sv
// Run controller: counts cycles from start, detects halt/timeout, drains, then snapshots pc/watch.
// Latency: done rises DRAIN_CYCLES edges after detection; no backpressure, start is ignored while running.
// Backpressure: none; status and snapshots hold in DONE until the next start or reset.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int DATA_W       = 32,
    parameter int NUM_WATCH    = 4,
    parameter int CYC_W        = 16,
    parameter int MAX_CYCLES   = 1000,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        halt,
    input  logic [PC_W-1:0]             pc,
    input  logic [NUM_WATCH*DATA_W-1:0] watch,
    output logic                        running,
    output logic                        done,
    output logic                        timed_out,
    output logic [CYC_W-1:0]            cycle,
    output logic [CYC_W-1:0]            snap_cycle,
    output logic [PC_W-1:0]             snap_pc,
    output logic [NUM_WATCH*DATA_W-1:0] snap_watch
);

    if (!params_ok(CYC_W, MAX_CYCLES, DRAIN_CYCLES, NUM_WATCH)) begin : g_param_check
        $error("cpu_run_monitor: illegal parameter combination");
    end

    localparam logic [CYC_W-1:0]       MAX_CNT    = CYC_W'(MAX_CYCLES);
    localparam bit                     ZERO_DRAIN = (DRAIN_CYCLES == 0);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT =
        ZERO_DRAIN ? '0 : DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    run_state_e             state_q, state_d;
    logic [CYC_W-1:0]       cycle_q, cycle_d;
    logic [CYC_W-1:0]       snap_cycle_q, snap_cycle_d;
    logic                   timed_out_q, timed_out_d;
    logic [PC_W-1:0]        snap_pc_q, snap_pc_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   snap_clr;
    logic                   snap_cap;

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        snap_cycle_d = snap_cycle_q;
        timed_out_d  = timed_out_q;
        snap_pc_d    = snap_pc_q;
        drain_cnt_d  = drain_cnt_q;
        snap_clr     = 1'b0;
        snap_cap     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    cycle_d      = '0;
                    snap_cycle_d = '0;
                    timed_out_d  = 1'b0;
                    snap_pc_d    = '0;
                    snap_clr     = 1'b1;
                end
            end
            ST_RUN: begin
                // Halt outranks the limit when both land on the same edge.
                if (halt || (cycle_q == MAX_CNT)) begin
                    snap_cycle_d = cycle_q;
                    timed_out_d  = !halt;
                    if (ZERO_DRAIN) begin
                        state_d   = ST_DONE;
                        snap_pc_d = pc;
                        snap_cap  = 1'b1;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_INIT;
                    end
                end else begin
                    cycle_d = cycle_q + CYC_W'(1);
                end
            end
            ST_DRAIN: begin
                cycle_d = cycle_q + CYC_W'(1);
                if (drain_cnt_q == '0) begin
                    state_d   = ST_DONE;
                    snap_pc_d = pc;
                    snap_cap  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cycle_q      <= '0;
            snap_cycle_q <= '0;
            timed_out_q  <= 1'b0;
            snap_pc_q    <= '0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            snap_cycle_q <= snap_cycle_d;
            timed_out_q  <= timed_out_d;
            snap_pc_q    <= snap_pc_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_WATCH; i++) begin : g_snap
        logic [DATA_W-1:0] snap_watch_q, snap_watch_d;

        always_comb begin
            snap_watch_d = snap_watch_q;
            if (snap_clr) begin
                snap_watch_d = '0;
            end else if (snap_cap) begin
                snap_watch_d = watch[i*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                snap_watch_q <= '0;
            end else begin
                snap_watch_q <= snap_watch_d;
            end
        end

        assign snap_watch[i*DATA_W +: DATA_W] = snap_watch_q;
    end

    assign running    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign timed_out  = timed_out_q;
    assign cycle      = cycle_q;
    assign snap_cycle = snap_cycle_q;
    assign snap_pc    = snap_pc_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized bench for cpu_run_monitor: two instances (drain 2 and drain 0) against a run-level model.
module tb_cpu_run_monitor;

    localparam int PC_W  = 32;
    localparam int DW    = 32;
    localparam int NW    = 4;
    localparam int CW    = 16;
    localparam int MAX   = 20;
    localparam int WW    = NW * DW;

    logic          clk = 1'b0;
    logic          reset, start, halt;
    logic [PC_W-1:0] pc;
    logic [WW-1:0]   watch;

    logic            running_o   [2];
    logic            done_o      [2];
    logic            timed_out_o [2];
    logic [CW-1:0]   cycle_o     [2];
    logic [CW-1:0]   snap_cycle_o[2];
    logic [PC_W-1:0] snap_pc_o   [2];
    logic [WW-1:0]   snap_watch_o[2];

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .PC_W(PC_W), .DATA_W(DW), .NUM_WATCH(NW), .CYC_W(CW),
        .MAX_CYCLES(MAX), .DRAIN_CYCLES(2)
    ) u_dut_drain (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .pc(pc), .watch(watch),
        .running(running_o[0]), .done(done_o[0]), .timed_out(timed_out_o[0]),
        .cycle(cycle_o[0]), .snap_cycle(snap_cycle_o[0]), .snap_pc(snap_pc_o[0]),
        .snap_watch(snap_watch_o[0])
    );

    cpu_run_monitor #(
        .PC_W(PC_W), .DATA_W(DW), .NUM_WATCH(NW), .CYC_W(CW),
        .MAX_CYCLES(MAX), .DRAIN_CYCLES(0)
    ) u_dut_nodrain (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .pc(pc), .watch(watch),
        .running(running_o[1]), .done(done_o[1]), .timed_out(timed_out_o[1]),
        .cycle(cycle_o[1]), .snap_cycle(snap_cycle_o[1]), .snap_pc(snap_pc_o[1]),
        .snap_watch(snap_watch_o[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Run-level model: a run is "active" from start until its snapshot; after the
    // stop event it still needs drain_len more edges before results are published.
    int          drain_len[2] = '{2, 0};
    bit          m_active [2];
    bit          m_stopped[2];
    bit          m_done   [2];
    bit          m_to     [2];
    int          m_cyc    [2];
    int          m_snapc  [2];
    int          m_left   [2];
    logic [PC_W-1:0] m_pc [2];
    logic [WW-1:0]   m_w  [2];

    function automatic void publish(input int k);
        m_pc[k]      = pc;
        m_w[k]       = watch;
        m_done[k]    = 1'b1;
        m_active[k]  = 1'b0;
        m_stopped[k] = 1'b0;
    endfunction

    function automatic void model_step(input int k);
        if (reset) begin
            m_active[k] = 0; m_stopped[k] = 0; m_done[k] = 0; m_to[k] = 0;
            m_cyc[k] = 0; m_snapc[k] = 0; m_left[k] = 0; m_pc[k] = '0; m_w[k] = '0;
        end else if (!m_active[k]) begin
            if (start) begin
                m_active[k] = 1; m_stopped[k] = 0; m_done[k] = 0; m_to[k] = 0;
                m_cyc[k] = 0; m_snapc[k] = 0; m_pc[k] = '0; m_w[k] = '0;
            end
        end else if (!m_stopped[k]) begin
            if (halt || m_cyc[k] == MAX) begin
                m_stopped[k] = 1;
                m_snapc[k]   = m_cyc[k];
                m_to[k]      = !halt;
                m_left[k]    = drain_len[k];
                if (m_left[k] == 0) publish(k);
            end else begin
                m_cyc[k]++;
            end
        end else begin
            m_cyc[k]++;
            m_left[k]--;
            if (m_left[k] == 0) publish(k);
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("running%0d", k),    128'(running_o[k]),    128'(m_active[k]));
            check($sformatf("done%0d", k),       128'(done_o[k]),       128'(m_done[k]));
            check($sformatf("timed_out%0d", k),  128'(timed_out_o[k]),  128'(m_to[k]));
            check($sformatf("cycle%0d", k),      128'(cycle_o[k]),      128'(m_cyc[k]));
            check($sformatf("snap_cycle%0d", k), 128'(snap_cycle_o[k]), 128'(m_snapc[k]));
            check($sformatf("snap_pc%0d", k),    128'(snap_pc_o[k]),    128'(m_pc[k]));
            check($sformatf("snap_watch%0d", k), 128'(snap_watch_o[k]), 128'(m_w[k]));
        end
    endtask

    task automatic edge_and_check();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick(input bit r, input bit s, input bit h);
        reset = r; start = s; halt = h;
        pc    = $urandom;
        watch = {$urandom, $urandom, $urandom, $urandom};
        edge_and_check();
    endtask

    task automatic tick_fixed(input bit r, input bit s, input bit h);
        reset = r; start = s; halt = h;
        pc    = 32'h40;
        watch = {32'h2A, $urandom, $urandom, $urandom};
        edge_and_check();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt = 1'b0; pc = '0; watch = '0;

        // Reset state
        tick(1, 0, 0);
        tick(1, 0, 0);
        check("reset_done", 128'(done_o[0]), 128'(0));
        check("reset_cycle", 128'(cycle_o[0]), 128'(0));

        // Halt path: halt while cycle==5, drain 2
        tick(0, 1, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        tick(0, 0, 1);
        check("nodrain_done_at_detect", 128'(done_o[1]), 128'(1));
        check("drain_still_running", 128'(running_o[0]), 128'(1));
        tick(0, 0, 1);
        tick_fixed(0, 0, 0);
        check("halt_done", 128'(done_o[0]), 128'(1));
        check("halt_snap_cycle", 128'(snap_cycle_o[0]), 128'(5));
        check("halt_timed_out", 128'(timed_out_o[0]), 128'(0));
        check("halt_cycle", 128'(cycle_o[0]), 128'(7));
        check("halt_snap_pc", 128'(snap_pc_o[0]), 128'(32'h40));
        check("halt_watch3", 128'(snap_watch_o[0][3*DW +: DW]), 128'(32'h2A));
        tick(0, 0, 0);
        check("done_hold_cycle", 128'(cycle_o[0]), 128'(7));

        // Restart from DONE, with start pulses during the run ignored
        tick(0, 1, 0);
        check("restart_snap_cleared", 128'(snap_pc_o[0]), 128'(0));
        check("restart_cycle0", 128'(cycle_o[0]), 128'(0));
        for (int i = 0; i < 6; i++) tick(0, i[0], 0);
        check("start_ignored_cycle", 128'(cycle_o[0]), 128'(6));

        // Timeout path
        for (int i = 0; i < 20; i++) tick(0, 0, 0);
        check("timeout_done", 128'(done_o[0]), 128'(1));
        check("timeout_flag", 128'(timed_out_o[0]), 128'(1));
        check("timeout_snap_cycle", 128'(snap_cycle_o[0]), 128'(MAX));
        check("timeout_cycle", 128'(cycle_o[0]), 128'(MAX + 2));

        // Halt on the limit edge: halt wins
        tick(0, 1, 0);
        for (int i = 0; i < MAX; i++) tick(0, 0, 0);
        tick(0, 0, 1);
        check("simul_nodrain_to", 128'(timed_out_o[1]), 128'(0));
        check("simul_nodrain_snap", 128'(snap_cycle_o[1]), 128'(MAX));
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("simul_drain_to", 128'(timed_out_o[0]), 128'(0));
        check("simul_drain_done", 128'(done_o[0]), 128'(1));

        // Reset in the middle of the drain
        tick(0, 1, 0);
        tick(0, 0, 0);
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check("middrain_running", 128'(running_o[0]), 128'(0));
        check("middrain_snap_cycle", 128'(snap_cycle_o[0]), 128'(0));
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        check("middrain_no_done", 128'(done_o[0]), 128'(0));
        tick(0, 1, 0);
        tick(0, 0, 0);
        check("after_reset_run", 128'(cycle_o[0]), 128'(1));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 200) == 0, ($urandom % 16) == 0, ($urandom % 12) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
